conv_result_serializer: RTL and testbench

Downstream stage of the circular convolution core. Captures each completed result window (a one-cycle `in_valid` pulse carrying `WINDOW_SIZE` parallel words, no backpressure possible) into a two-slot ping-pong buffer and streams it out one word per handshake on a valid/ready interface. Element 0 goes first, and `out_last` marks element `WINDOW_SIZE-1`. Windows that arrive while both slots are occupied are dropped and flagged.

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_window_pingpong.sv | 75 +++++++
 rtl/conv_result_serializer.sv | 137 +++++++++++++
 tb/tb_conv_result_serializer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the circular convolution core and its result serializer.
package conv_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

  localparam int DROP_CNT_W          = 16;
  localparam int DEFAULT_QLEN        = 16;
  localparam int DEFAULT_WINDOW_SIZE = 16;

endpackage

// File: rtl/conv_window_pingpong.sv
// Two-slot window buffer: full flags, write/read slot pointers, accept/drop decision
// and a look-ahead word-select read port.
module conv_window_pingpong
  import conv_pkg::*;
#(
  parameter int QLEN        = DEFAULT_QLEN,
  parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
  parameter int IDX_W       = $clog2(WINDOW_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [WINDOW_SIZE-1:0][QLEN-1:0]  in_data,
  input  logic                              rd_release,
  input  logic [IDX_W-1:0]                  rd_idx,
  output logic                              rd_full_nxt,
  output logic [QLEN-1:0]                   rd_word_nxt,
  output logic                              drop,
  output logic [1:0]                        full
);

  logic [WINDOW_SIZE-1:0][QLEN-1:0] slot_r [2];
  logic [1:0] full_r;
  logic       wr_sel_r;
  logic       rd_sel_r;

  logic       wr_free_s;
  logic       accept_s;
  logic [1:0] clr_s;
  logic [1:0] set_s;
  logic [1:0] full_nxt_s;
  logic       rd_sel_nxt_s;

  // A release of the slot being written in this same cycle frees it first.
  assign wr_free_s    = !full_r[wr_sel_r] || (rd_release && (rd_sel_r == wr_sel_r));
  assign accept_s     = in_valid && wr_free_s;
  assign drop         = in_valid && !wr_free_s;
  assign clr_s        = rd_release ? (2'b01 << rd_sel_r) : 2'b00;
  assign set_s        = accept_s ? (2'b01 << wr_sel_r) : 2'b00;
  assign full_nxt_s   = (full_r & ~clr_s) | set_s;
  assign rd_sel_nxt_s = rd_sel_r ^ rd_release;
  assign rd_full_nxt  = full_nxt_s[rd_sel_nxt_s];
  assign full         = full_r;

  // Word that the read side will present after this edge, bypassing a window landing now.
  always_comb begin
    rd_word_nxt = slot_r[rd_sel_nxt_s][rd_idx];
    if (accept_s && (wr_sel_r == rd_sel_nxt_s)) begin
      rd_word_nxt = in_data[rd_idx];
    end else begin
      rd_word_nxt = slot_r[rd_sel_nxt_s][rd_idx];
    end
  end

  // Slot bookkeeping state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r   <= 2'b00;
      wr_sel_r <= 1'b0;
      rd_sel_r <= 1'b0;
    end else begin
      full_r   <= full_nxt_s;
      wr_sel_r <= wr_sel_r ^ accept_s;
      rd_sel_r <= rd_sel_nxt_s;
    end
  end

  // Window storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      slot_r[wr_sel_r] <= in_data;
    end
  end

endmodule

// File: rtl/conv_result_serializer.sv
// Serializes captured convolution result windows onto a valid/ready word stream.
// Optional feature macro: CONV_SERIALIZER_DROP_CNT_EN enables the saturating drop counter.
module conv_result_serializer
  import conv_pkg::*;
#(
  parameter int QLEN        = DEFAULT_QLEN,
  parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [WINDOW_SIZE-1:0][QLEN-1:0]  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [QLEN-1:0]                   out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overflow,
  output logic [DROP_CNT_W-1:0]             drop_count
);

  localparam int IDX_W = $clog2(WINDOW_SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW_SIZE - 1);

  ser_state_e       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  logic             out_valid_r;
  logic [QLEN-1:0]  out_data_r;
  logic             out_last_r;
  logic             overflow_r;

  logic             xfer_s;
  logic             last_xfer_s;
  logic             rd_full_nxt_s;
  logic [QLEN-1:0]  rd_word_nxt_s;
  logic             drop_s;
  logic [1:0]       full_s;

  assign xfer_s      = out_valid_r && out_ready;
  assign last_xfer_s = xfer_s && out_last_r;

  // Word index for the cycle after this edge.
  always_comb begin
    idx_nxt_s = idx_r;
    if (last_xfer_s) begin
      idx_nxt_s = {IDX_W{1'b0}};
    end else if (xfer_s) begin
      idx_nxt_s = idx_r + IDX_W'(1);
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  conv_window_pingpong #(
    .QLEN        (QLEN),
    .WINDOW_SIZE (WINDOW_SIZE),
    .IDX_W       (IDX_W)
  ) u_pingpong (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .rd_release  (last_xfer_s),
    .rd_idx      (idx_nxt_s),
    .rd_full_nxt (rd_full_nxt_s),
    .rd_word_nxt (rd_word_nxt_s),
    .drop        (drop_s),
    .full        (full_s)
  );

  // Output FSM; outputs are loaded from the look-ahead read port so a fresh window shows next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {QLEN{1'b0}};
      out_last_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      idx_r      <= idx_nxt_s;
      overflow_r <= drop_s;
      case (state_r)
        ST_IDLE: begin
          if (rd_full_nxt_s) begin
            state_r     <= ST_STREAM;
            out_valid_r <= 1'b1;
            out_data_r  <= rd_word_nxt_s;
            out_last_r  <= (idx_nxt_s == IDX_LAST);
          end
        end
        ST_STREAM: begin
          if (xfer_s) begin
            if (rd_full_nxt_s) begin
              out_data_r <= rd_word_nxt_s;
              out_last_r <= (idx_nxt_s == IDX_LAST);
            end else begin
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_SERIALIZER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_count_r;

  // Saturating count of dropped windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_r <= {DROP_CNT_W{1'b0}};
    end else if (drop_s && (drop_count_r != {DROP_CNT_W{1'b1}})) begin
      drop_count_r <= drop_count_r + DROP_CNT_W'(1);
    end
  end

  assign drop_count = drop_count_r;
`else
  assign drop_count = {DROP_CNT_W{1'b0}};
`endif

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign overflow  = overflow_r;
  assign busy      = |full_s;

endmodule

// File: tb/tb_conv_result_serializer.sv
// Directed table-driven bench for conv_result_serializer with QLEN=8, WINDOW_SIZE=4.
module tb_conv_result_serializer;

  localparam int QLEN = 8;
  localparam int WS   = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic [WS-1:0][QLEN-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [QLEN-1:0]        out_data;
  logic                   out_last;
  logic                   busy;
  logic                   overflow;
  logic [15:0]            drop_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        eb;
    logic        eo;
  } vec_t;

  vec_t vq[$];

`ifdef CONV_SERIALIZER_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP_ONE = 16'd1;
`else
  localparam logic [15:0] EXP_DROP_ONE = 16'd0;
`endif

  conv_result_serializer #(.QLEN(QLEN), .WINDOW_SIZE(WS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic add(input logic iv, input logic [31:0] din, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic eb, input logic eo);
    vec_t v;
    v.iv = iv; v.din = din; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.eo = eo;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] held;
    logic       stalled;
    int         n;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid",  32'(out_valid),  32'd0);
    chk("reset out_last",   32'(out_last),   32'd0);
    chk("reset out_data",   32'(out_data),   32'd0);
    chk("reset busy",       32'(busy),       32'd0);
    chk("reset overflow",   32'(overflow),   32'd0);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single window
    add(1, 32'h04030201, 1, 1, 8'h01, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h02, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h03, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h04, 1, 1, 0);
    add(0, 32'h0,        1, 0, 8'h00, 0, 0, 0);
    // Two windows back to back, no gap
    add(1, 32'h14131211, 1, 1, 8'h11, 0, 1, 0);
    add(1, 32'h24232221, 1, 1, 8'h12, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h13, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h14, 1, 1, 0);
    add(0, 32'h0,        1, 1, 8'h21, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h22, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h23, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h24, 1, 1, 0);
    add(0, 32'h0,        1, 0, 8'h00, 0, 0, 0);
    // Third window while both slots held and consumer stalled
    add(1, 32'h14131211, 0, 1, 8'h11, 0, 1, 0);
    add(1, 32'h24232221, 0, 1, 8'h11, 0, 1, 0);
    add(1, 32'h34333231, 0, 1, 8'h11, 0, 1, 1);
    add(0, 32'h0,        0, 1, 8'h11, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h12, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h13, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h14, 1, 1, 0);
    add(0, 32'h0,        1, 1, 8'h21, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h22, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h23, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h24, 1, 1, 0);
    add(0, 32'h0,        1, 0, 8'h00, 0, 0, 0);
    // Capture coincides with final-word release while both slots are full
    add(1, 32'h14131211, 0, 1, 8'h11, 0, 1, 0);
    add(1, 32'h24232221, 0, 1, 8'h11, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h12, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h13, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h14, 1, 1, 0);
    add(1, 32'h44434241, 1, 1, 8'h21, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h22, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h23, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h24, 1, 1, 0);
    add(0, 32'h0,        1, 1, 8'h41, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h42, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h43, 0, 1, 0);
    add(0, 32'h0,        1, 1, 8'h44, 1, 1, 0);
    add(0, 32'h0,        1, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      in_valid  = vq[i].iv;
      in_data   = vq[i].din;
      out_ready = vq[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vq[i].ev));
      chk($sformatf("vec%0d busy", i),      32'(busy),      32'(vq[i].eb));
      chk($sformatf("vec%0d overflow", i),  32'(overflow),  32'(vq[i].eo));
      if (vq[i].ev) begin
        chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vq[i].ed));
        chk($sformatf("vec%0d out_last", i), 32'(out_last), 32'(vq[i].el));
      end
    end
    chk("drop_count after drop", 32'(drop_count), 32'(EXP_DROP_ONE));

    // Backpressure with ready pattern 1,0,0,1
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h54535251; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0; stalled = 1'b0; held = 8'h00;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (stalled) chk($sformatf("bp hold c%0d", c), 32'(out_data), 32'(held));
      if (out_valid && out_ready) begin
        chk($sformatf("bp word%0d", n), 32'(out_data), 32'(8'h51 + n));
        chk($sformatf("bp last%0d", n), 32'(out_last), 32'(n == 3));
        n++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      @(posedge clk);
      #1;
    end
    chk("bp transfer count", 32'(n), 32'd4);
    chk("bp busy after", 32'(busy), 32'd0);

    // Reset during word 2
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h64636261; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst pre word1", 32'(out_data), 32'h61);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst pre word2", 32'(out_data), 32'h62);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst out_valid",  32'(out_valid),  32'd0);
    chk("rst busy",       32'(busy),       32'd0);
    chk("rst out_last",   32'(out_last),   32'd0);
    chk("rst drop_count", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst idle%0d", c), 32'(out_valid | out_last), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h74737271;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post-rst restart valid", 32'(out_valid), 32'd1);
    chk("post-rst restart data",  32'(out_data),  32'h71);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
